io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter and responder on the io side of system_bus.
- The CPU writes bytes into a TX FIFO through the io_* bus signals.
- A baud counter and shift FSM serialise each byte as 8N1 on the tx pin.
- Sits beside the io/VGA controller; it is the device end of the CPU-initiated io transactions.

Parameters:
- BASE_ADDR, 32'h0000_3000, base of the 16-byte register window; decode on io_addr[31:4] == BASE_ADDR[31:4].
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 16'd434, reset value of BAUD_DIV (50 MHz / 115200).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- io_addr  in  32  byte address from system_bus.
- io_write_data  in  32  write data from system_bus.
- io_write_en  in  1  write strobe; sampled at posedge.
- io_read_data  out  32  read data; combinational from io_addr and current state; 0 when the address is not decoded.
- tx  out  1  serial output; idles high.

Behaviour:
- Register map (offset = io_addr[3:0]):
  - 0x0 TXDATA: write pushes io_write_data[7:0]; reads 0.
  - 0x4 STATUS (RO): bit0 busy (FSM != IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[10:4] fifo count; other bits 0.
  - 0x8 BAUD_DIV (RW): bits[15:0]; reads zero-extended.
  - 0xC CTRL (RW): bit0 enable, bit2 irq_en. Bit1 is write-1-clears overflow and reads 0.
- Offsets 0x1-0x3, 0x5-0x7 etc.: word aligned only; io_addr[1:0] ignored.
- Reset values: tx=1, FIFO empty, count=0, overflow=0, BAUD_DIV=DEFAULT_DIV, CTRL=0, FSM=IDLE, io_read_data reflects the reset state.
- Push:
  - Accepted if the FIFO is not full before the edge.
  - Write while full: data dropped, overflow set. A simultaneous pop in that cycle does not rescue the write.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if enable and not empty, pop the head into shreg, latch div_q = max(BAUD_DIV, 1), clear bit index, go to START.
  - START: tx=0 for div_q cycles, then DATA.
  - DATA: tx=shreg[0] LSB first; each div_q cycles shift right and increment index; after bit 7 go to STOP.
  - STOP: tx=1 for div_q cycles, then IDLE.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between frames.
- Latency: push at edge N with FIFO empty and enable=1 gives count=1 after N, pop and START at N+1, tx falls after N+1.
  - One frame = 10*div_q cycles in START+DATA+STOP.
- Simultaneous push and pop: count unchanged, both take effect.
- BAUD_DIV write mid-frame: no effect until the next frame (div_q latched).
- BAUD_DIV=0 behaves as 1.
- enable cleared mid-frame: current frame completes, then FSM holds in IDLE; the FIFO still accepts pushes.
- Reset mid-frame: tx high immediately (async), frame aborted, FIFO contents discarded.
- Pointers wrap modulo FIFO_DEPTH; count is a separate log2(FIFO_DEPTH)+1-bit register.

Optional Feature:
- Macro: IO_UART_TX_IRQ_EN.
- Defined: adds output port irq (1 bit), registered; irq = irq_en & empty & (FSM==IDLE); reset 0.
- Undefined: no irq port; CTRL bit2 is still writable and readable but has no effect.

Decomposition:
- Package uart_tx_pkg holds:
  - register offsets: TXDATA_OFF, STATUS_OFF, BAUD_OFF, CTRL_OFF;
  - STATUS/CTRL bit positions;
  - state enum tx_state_t {IDLE, START, DATA, STOP}.
- Sub-module sync_fifo:
  - parameters WIDTH=8 and DEPTH;
  - ports: push, pop, din, dout, full, empty, count;
  - asynchronous active-low reset.
- The top level holds the bus decode, registers, baud counter and FSM.

Test Plan:
- Reset: drive reset=0 for 2 cycles, then release, read 0x4 -> 0x004 (empty=1, count=0); read 0x8 -> 434; tx=1.
- Single byte: set BAUD_DIV=4, CTRL=1, write 0xA5 to 0x0 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; busy=1 during the frame; empty=1 afterwards.
- Burst/overflow: CTRL=0, write 17 bytes -> count=16, full=1, overflow=1.
  - Write CTRL=0x3 -> overflow=0; 16 frames sent back-to-back with 1 IDLE cycle between frames.
- Mid-frame BAUD_DIV change: DIV=4, send 0x00, write DIV=8 during bit 3 -> that frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
- Reset mid-frame: assert reset during DATA of 0x0F with 3 bytes queued -> tx=1 at once; after release count=0 and no further frames.
- IO_UART_TX_IRQ_EN build: CTRL=0x5, send one byte -> irq=0 while busy, irq=1 one cycle after the return to IDLE; write CTRL=0x1 -> irq=0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the io-side UART transmitter: register offsets,
// STATUS/CTRL bit positions, the serialiser state type and a divisor helper.
package uart_tx_pkg;

    // Register offsets inside the 16-byte window (word aligned)
    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] BAUD_OFF   = 4'h8;
    localparam logic [3:0] CTRL_OFF   = 4'hC;

    // STATUS bit positions
    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 7;

    // CTRL bit positions
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_OVF_CLR_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // A divisor of zero would never produce a bit tick, so it runs as 1
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter. Pushes while full and
// pops while empty are ignored; dout always shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage write; entries are only ever read after being written
    // NOTE: the data array has no reset - occupancy is tracked by count/pointers,
    // so clearing it would only add reset fan-out without changing behaviour.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the io side of system_bus.
// The CPU pushes bytes into a TX FIFO; a baud counter and a four-state
// serialiser shift them out LSB first on tx.
// Optional feature: define IO_UART_TX_IRQ_EN to add the registered irq output
// (irq_en & FIFO empty & serialiser idle).
module io_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_write_data,
    input  logic        io_write_en,
    output logic [31:0] io_read_data,
    output logic        tx
`ifdef IO_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic        hit;
    logic [3:0]  reg_off;
    logic        wr_txdata;
    logic        wr_baud;
    logic        wr_ctrl;

    // Software-visible registers
    logic [15:0] baud_div;
    logic        enable;
    logic        irq_en;
    logic        overflow;

    // FIFO interface
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        pop;

    // Serialiser
    tx_state_t   state;
    tx_state_t   next_state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic [15:0] div_q;
    logic        tick;
    logic [31:0] status;

    // Byte-lane bits the register map never looks at
    logic        unused_bits;
    assign unused_bits = ^{io_addr[1:0], io_write_data[31:16]};

    assign hit       = (io_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_off   = {io_addr[3:2], 2'b00};
    assign wr_txdata = io_write_en & hit & (reg_off == TXDATA_OFF);
    assign wr_baud   = io_write_en & hit & (reg_off == BAUD_OFF);
    assign wr_ctrl   = io_write_en & hit & (reg_off == CTRL_OFF);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (io_write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register writes; a push that finds the FIFO full is dropped and flagged
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_div <= DEFAULT_DIV;
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_baud) baud_div <= io_write_data[15:0];
            if (wr_ctrl) begin
                enable <= io_write_data[CTRL_EN_BIT];
                irq_en <= io_write_data[CTRL_IRQ_EN_BIT];
            end
            if (wr_txdata && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_ctrl && io_write_data[CTRL_OVF_CLR_BIT]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Last cycle of the current bit period
    assign tick = (baud_cnt == div_q - 16'd1);

    // Serialiser state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next state, FIFO pop and line level; tx follows state so reset forces it high at once
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        tx         = 1'b1;
        unique case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) next_state = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (tick && bit_idx == 3'd7) next_state = STOP;
            end
            STOP: begin
                if (tick) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame datapath: load on pop, then count bit periods and shift data bits out
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            div_q    <= 16'd1;
        end else if (pop) begin
            shreg    <= fifo_dout;
            div_q    <= eff_div(baud_div);
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else if (state != IDLE) begin
            if (tick) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        status                               = '0;
        status[ST_BUSY_BIT]                  = (state != IDLE);
        status[ST_FULL_BIT]                  = fifo_full;
        status[ST_EMPTY_BIT]                 = fifo_empty;
        status[ST_OVF_BIT]                   = overflow;
        status[ST_COUNT_LSB +: ST_COUNT_W]   = ST_COUNT_W'(fifo_count);
    end

    // Read mux; undecoded addresses and TXDATA read as zero
    always_comb begin
        io_read_data = '0;
        if (hit) begin
            unique case (reg_off)
                STATUS_OFF: io_read_data = status;
                BAUD_OFF:   io_read_data = {16'h0000, baud_div};
                CTRL_OFF:   io_read_data = {29'd0, irq_en, 1'b0, enable};
                default:    io_read_data = '0;
            endcase
        end
    end

`ifdef IO_UART_TX_IRQ_EN
    // Interrupt when enabled and the transmitter has fully drained
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= irq_en & fifo_empty & (state == IDLE);
    end
`endif

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx. A frame-level model predicts tx (and irq
// when IO_UART_TX_IRQ_EN is defined) on every cycle; directed sequences pin
// the model with hand-computed waveforms, status words and cycle counts.
module tb_io_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_write_data = '0;
    logic        io_write_en = 1'b0;
    logic [31:0] io_read_data;
    logic        tx;
`ifdef IO_UART_TX_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    io_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (16),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_addr       (io_addr),
        .io_write_data (io_write_data),
        .io_write_en   (io_write_en),
        .io_read_data  (io_read_data),
        .tx            (tx)
`ifdef IO_UART_TX_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    logic [9:0]  m_frame  = 10'h3FF;
    int          m_d      = 1;
    int          m_pos    = 0;
    logic [15:0] m_div    = 16'd434;
    bit          m_en     = 1'b0;
    bit          m_irq_en = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_irq    = 1'b0;
    bit          m_hit;
    bit          m_was_full;
    logic [7:0]  m_byte;
    logic        exp_tx;

    // A frame is the 10-bit vector {stop, data, start}; each bit lasts m_d cycles
    assign exp_tx = m_active ? m_frame[m_pos / m_d] : 1'b1;

    function automatic logic [31:0] m_status();
        return {21'd0, 7'(m_q.size()), m_ovf, (m_q.size() == 0), (m_q.size() == 16), m_active};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_div    = 16'd434;
            m_en     = 1'b0;
            m_irq_en = 1'b0;
            m_ovf    = 1'b0;
            m_irq    = 1'b0;
        end else begin
            m_hit      = (io_addr[31:4] == BASE[31:4]);
            m_was_full = (m_q.size() == 16);
            m_irq      = m_irq_en && (m_q.size() == 0) && !m_active;
            if (m_active) begin
                if (m_pos == 10 * m_d - 1) m_active = 1'b0;
                else                       m_pos++;
            end else if (m_en && m_q.size() != 0) begin
                m_byte   = m_q.pop_front();
                m_frame  = {1'b1, m_byte, 1'b0};
                m_d      = (m_div == 16'd0) ? 1 : int'(m_div);
                m_pos    = 0;
                m_active = 1'b1;
            end
            if (io_write_en && m_hit) begin
                case (io_addr[3:2])
                    2'd0: if (m_was_full) m_ovf = 1'b1;
                          else            m_q.push_back(io_write_data[7:0]);
                    2'd2: m_div = io_write_data[15:0];
                    2'd3: begin
                        m_en     = io_write_data[0];
                        m_irq_en = io_write_data[2];
                        if (io_write_data[1]) m_ovf = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (reset) begin
            check("tx_vs_model", {31'd0, tx}, {31'd0, exp_tx});
`ifdef IO_UART_TX_IRQ_EN
            check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
`endif
        end
    end

    // ---------------- bus helpers (entered and left around a negedge) ----------------
    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        io_addr       = {BASE[31:4], off};
        io_write_data = data;
        io_write_en   = 1'b1;
        @(negedge clock);
        io_write_en   = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        io_addr = addr;
        #1;
        check(name, io_read_data, exp);
    endtask

    task automatic status_check(input string name, input logic [31:0] exp);
        read_check(name, {BASE[31:4], 4'h4}, exp);
        check({name, "_model"}, io_read_data, m_status());
    endtask

    // Counts cycles until STATUS reads idle+empty with no overflow
    task automatic wait_idle(input int budget, output int cycles);
        cycles  = -1;
        io_addr = {BASE[31:4], 4'h4};
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            #1;
            if (io_read_data == 32'h4) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [9:0] a5_bits;
    bit         found;
    int         cyc;
    int         low_cycles;

    initial begin
        a5_bits = 10'b1101001010;

        // ---- reset ----
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        status_check("reset_status", 32'h0000_0004);
        read_check("reset_baud", {BASE[31:4], 4'h8}, 32'd434);
        read_check("reset_ctrl", {BASE[31:4], 4'hC}, 32'd0);
        read_check("txdata_reads_zero", {BASE[31:4], 4'h0}, 32'd0);
        read_check("unmapped_zero", 32'h0000_3108, 32'd0);
        read_check("misaligned_baud", 32'h0000_300A, 32'd434);

        // ---- single byte 0xA5 at 4 cycles per bit ----
        @(negedge clock);
        bus_write(4'h8, 32'd4);
        bus_write(4'hC, 32'd1);
        bus_write(4'h0, 32'h0000_00A5);
        io_addr = {BASE[31:4], 4'h4};
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (tx === 1'b0) found = 1'b1;
        end
        check("a5_start_seen", {31'd0, found}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("a5_wave_c%0d", k), {31'd0, tx}, {31'd0, a5_bits[k / 4]});
            if (k == 0 || k == 39) check($sformatf("a5_busy_c%0d", k), {31'd0, io_read_data[0]}, 32'd1);
            @(negedge clock);
        end
        check("a5_done_status", io_read_data, 32'h0000_0004);

        // ---- burst of 17 with enable off, then drain ----
        bus_write(4'hC, 32'd0);
        for (int i = 0; i < 17; i++) bus_write(4'h0, (i * 37 + 5) & 32'hFF);
        status_check("burst_full_ovf", 32'h0000_010A);
        bus_write(4'hC, 32'd3);
        status_check("ovf_cleared", 32'h0000_0102);
        wait_idle(800, cyc);
        check("burst_cycles", cyc, 32'd656);

        // ---- BAUD_DIV change mid-frame ----
        @(negedge clock);
        bus_write(4'h0, 32'h00);
        bus_write(4'h0, 32'h81);
        status_check("push_pop_same_cycle", 32'h0000_0011);
        @(negedge clock);
        repeat (15) @(negedge clock);
        bus_write(4'h8, 32'd8);
        read_check("baud_now_8", {BASE[31:4], 4'h8}, 32'd8);
        wait_idle(300, cyc);
        check("div_change_cycles", cyc, 32'd104);

        // ---- BAUD_DIV = 0 runs as 1 ----
        @(negedge clock);
        bus_write(4'h8, 32'd0);
        read_check("baud_zero_reads", {BASE[31:4], 4'h8}, 32'd0);
        @(negedge clock);
        bus_write(4'h0, 32'h55);
        wait_idle(100, cyc);
        check("div0_cycles", cyc, 32'd11);

        // ---- reset in the middle of a frame ----
        @(negedge clock);
        bus_write(4'h8, 32'd4);
        bus_write(4'h0, 32'h0F);
        bus_write(4'h0, 32'h01);
        bus_write(4'h0, 32'h02);
        bus_write(4'h0, 32'h03);
        repeat (22) @(negedge clock);
        check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
        status_check("pre_reset_queued", 32'h0000_0031);
        #2;
        reset = 1'b0;
        #1;
        check("reset_tx_immediate", {31'd0, tx}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        status_check("post_reset_status", 32'h0000_0004);
        read_check("post_reset_ctrl", {BASE[31:4], 4'hC}, 32'd0);
        read_check("post_reset_baud", {BASE[31:4], 4'h8}, 32'd434);
        @(negedge clock);
        bus_write(4'hC, 32'd1);
        low_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (tx !== 1'b1) low_cycles++;
        end
        check("no_frames_after_reset", low_cycles, 32'd0);

        // ---- irq enable ----
        bus_write(4'h8, 32'd2);
        bus_write(4'hC, 32'd5);
        read_check("ctrl_irq_en_reads", {BASE[31:4], 4'hC}, 32'd5);
`ifdef IO_UART_TX_IRQ_EN
        check("irq_before_rise", {31'd0, irq}, 32'd0);
`endif
        @(negedge clock);
        bus_write(4'h0, 32'h3C);
`ifdef IO_UART_TX_IRQ_EN
        check("irq_idle_empty", {31'd0, irq}, 32'd1);
        @(negedge clock);
        check("irq_low_busy", {31'd0, irq}, 32'd0);
        wait_idle(100, cyc);
        check("irq_frame_cycles", cyc, 32'd20);
        check("irq_still_low_first_idle", {31'd0, irq}, 32'd0);
        @(negedge clock);
        check("irq_rises", {31'd0, irq}, 32'd1);
        bus_write(4'hC, 32'd1);
        @(negedge clock);
        check("irq_cleared", {31'd0, irq}, 32'd0);
`else
        wait_idle(100, cyc);
        check("irq_frame_cycles", cyc, 32'd21);
`endif

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
